hash_sched: RTL

HASH_SCHED -- requirements
Module: hash_sched

---
 rtl/hash_sched.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hash_sched.sv
// Round-robin scheduler feeding a fixed-latency hash pipeline and tagging its results.
// Define HASH_SCHED_STATS_EN to build the saturating per-requester grant counters.
module hash_sched #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 23,
  parameter int MAXLEN  = 250
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [8*NREQ-1:0]        req_len,
  input  logic [32*NREQ-1:0]       req_k0,
  input  logic [32*NREQ-1:0]       req_k1,
  input  logic [32*NREQ-1:0]       req_k2,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [7:0]               hp_len,
  output logic [31:0]              hp_k0,
  output logic [31:0]              hp_k1,
  output logic [31:0]              hp_k2,
  output logic                     hp_enable,
  input  logic [31:0]              hashkey,
  output logic                     res_valid,
  output logic [$clog2(NREQ)-1:0]  res_tag,
  output logic [31:0]              res_hash,
  output logic                     res_err,
  output logic                     busy,
  output logic [16*NREQ-1:0]       stat_grants
);

  localparam int TW = $clog2(NREQ);
  localparam int CW = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic [TW-1:0]   rr_ptr;
  logic [TW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            grant_ok;
  logic [7:0]      sel_len;
  logic [31:0]     sel_k0, sel_k1, sel_k2;
  logic            sel_legal;
  logic            iss_valid, iss_err;
  logic [TW-1:0]   iss_tag;
  logic            sr_valid [LATENCY];
  logic            sr_err   [LATENCY];
  logic [TW-1:0]   sr_tag   [LATENCY];
  logic [CW-1:0]   inflight;

  assign grant_ok = (state != DRAIN) && !flush;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    logic [TW:0] sum;
    req_ready = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    sum       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (TW+1)'(i);
      if (sum >= (TW+1)'(NREQ)) sum = sum - (TW+1)'(NREQ);
      if (grant_ok && !gnt_any && req_valid[sum[TW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = sum[TW-1:0];
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_len   = req_len[int'(gnt_idx)*8 +: 8];
  assign sel_k0    = req_k0[int'(gnt_idx)*32 +: 32];
  assign sel_k1    = req_k1[int'(gnt_idx)*32 +: 32];
  assign sel_k2    = req_k2[int'(gnt_idx)*32 +: 32];
  assign sel_legal = (sel_len != 8'd0) && ({24'd0, sel_len} <= 32'(MAXLEN));

  // The issue stage lines up with the hp_* register, so the result appears
  // LATENCY cycles after hp_enable, i.e. LATENCY+1 cycles after the accept.
  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr    <= '0;
      hp_len    <= '0;
      hp_k0     <= '0;
      hp_k1     <= '0;
      hp_k2     <= '0;
      hp_enable <= 1'b0;
      iss_valid <= 1'b0;
      iss_tag   <= '0;
      iss_err   <= 1'b0;
      inflight  <= '0;
      // NOTE: the tag shift register is control state, so it is cleared to drop in-flight work.
      for (int i = 0; i < LATENCY; i++) begin
        sr_valid[i] <= 1'b0;
        sr_tag[i]   <= '0;
        sr_err[i]   <= 1'b0;
      end
    end else begin
      if (gnt_any) rr_ptr <= (gnt_idx == TW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      hp_enable <= gnt_any && sel_legal;
      if (gnt_any && sel_legal) begin
        hp_len <= sel_len;
        hp_k0  <= sel_k0;
        hp_k1  <= sel_k1;
        hp_k2  <= sel_k2;
      end
      iss_valid <= gnt_any;
      iss_tag   <= gnt_idx;
      iss_err   <= gnt_any && !sel_legal;
      sr_valid[0] <= iss_valid;
      sr_tag[0]   <= iss_tag;
      sr_err[0]   <= iss_err;
      for (int i = 1; i < LATENCY; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_tag[i]   <= sr_tag[i-1];
        sr_err[i]   <= sr_err[i-1];
      end
      case ({gnt_any, res_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign res_valid = sr_valid[LATENCY-1];
  assign res_tag   = sr_tag[LATENCY-1];
  assign res_err   = sr_err[LATENCY-1];
  assign res_hash  = (res_valid && !res_err) ? hashkey : 32'd0;
  assign busy      = (inflight != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE:  if (|req_valid && !flush) state <= RUN;
        RUN: begin
          if (flush) state <= DRAIN;
          else if (!(|req_valid) && !busy) state <= IDLE;
        end
        DRAIN: begin
          if (inflight == '0) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HASH_SCHED_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_grants <= '0;
    end else if (gnt_any) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_idx == TW'(i) && stat_grants[16*i +: 16] != 16'hFFFF)
          stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
      end
    end
  end
`else
  assign stat_grants = '0;
`endif

endmodule
